// File: rtl/aes_dec_feeder.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_feeder
// Purpose  : Ingress stage in front of the pipelined AES-128 decryption core.
//            - Packs 32-bit ciphertext words into 128-bit blocks.
//            - Buffers the blocks in a small FIFO.
//            - Sequences key loading through the core's key-schedule FSM.
//            - Drains the core pipeline before a key change.
//            - Issues one block per cycle to the core while a key is ready.
// Ports    : clk        - clock
//            rst        - asynchronous reset, active low
//            key_in     - new key, sampled when key_load is accepted
//            key_load   - one-cycle key-change request
//            key_busy   - key change in progress; key_load ignored
//            key_ready  - key loaded, blocks are being issued
//            s_word     - ciphertext word; the first word of a block is [127:96]
//            s_valid    - s_word valid
//            s_ready    - word accepted when s_valid && s_ready
//            dec_IN     - block to the core
//            dec_KEY    - key to the core
//            dec_enable - core enable, one cycle per issued block
//            dec_fsm_en - one-cycle start pulse for the core key schedule
//            in_flight  - number of blocks inside the core pipeline
// Revision : 1.0 - initial release
// ============================================================================
module aes_dec_feeder #(
    parameter int BLOCK_LENGTH    = 128,
    parameter int WORD_W          = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int PIPE_DEPTH      = 11,
    parameter int KEY_LOAD_CYCLES = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_LENGTH-1:0] key_in,
    input  logic                    key_load,
    output logic                    key_busy,
    output logic                    key_ready,
    input  logic [WORD_W-1:0]       s_word,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [BLOCK_LENGTH-1:0] dec_IN,
    output logic [BLOCK_LENGTH-1:0] dec_KEY,
    output logic                    dec_enable,
    output logic                    dec_fsm_en,
    output logic [3:0]              in_flight
);

    localparam int c_WORDS = BLOCK_LENGTH / WORD_W;
    localparam int c_WC_W  = $clog2(c_WORDS);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_KC_W  = $clog2(KEY_LOAD_CYCLES + 1);
    localparam int c_ASM_W = BLOCK_LENGTH - WORD_W;

    localparam logic [c_WC_W-1:0]  c_LAST_WC = c_WC_W'(c_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_KC_W-1:0]  c_KC_INIT = c_KC_W'(KEY_LOAD_CYCLES);
    localparam logic [c_KC_W-1:0]  c_KC_ONE  = c_KC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_KEY_LOAD = 2'd1,
        S_RUN      = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Word packing. Only the leading words are stored; the final word
    // goes straight from s_word into the FIFO together with them.
    // ------------------------------------------------------------------
    logic [c_WC_W-1:0]       r_wc;
    logic [c_ASM_W-1:0]      r_asm;
    logic [BLOCK_LENGTH-1:0] w_block;
    logic                    w_last_word;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;

    // FIFO
    logic [BLOCK_LENGTH-1:0] r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    // Key sequencing
    logic [c_KC_W-1:0]       r_kcnt;
    logic [BLOCK_LENGTH-1:0] r_pend_key;
    logic [BLOCK_LENGTH-1:0] r_dec_key;
    logic [BLOCK_LENGTH-1:0] r_dec_in;
    logic                    r_fsm_en;
    logic                    w_enter_kl;
    logic                    w_key_from_in;
    logic                    w_key_from_pend;
    logic                    w_pend_capture;

    // Pipeline occupancy
    logic [PIPE_DEPTH-1:0]   r_en_sr;
    logic [3:0]              r_in_flight;

    assign w_fifo_full  = (r_count == c_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_last_word  = (r_wc == c_LAST_WC);

    // Only the block-completing word can be back-pressured. Uses the
    // registered count, so space freed by a pop shows up one cycle later.
    assign s_ready  = !w_last_word || !w_fifo_full;
    assign w_accept = s_valid && s_ready;
    assign w_push   = w_accept && w_last_word;
    assign w_pop    = (r_state == S_RUN) && !w_fifo_empty;
    assign w_block  = {r_asm, s_word};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wc  <= '0;
            r_asm <= '0;
        end else if (w_accept) begin
            if (!w_last_word) begin
                r_asm[c_ASM_W-1 - WORD_W*int'(r_wc) -: WORD_W] <= s_word;
                r_wc <= r_wc + c_WC_W'(1);
            end else begin
                r_wc <= '0;
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_block;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key / issue state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_enter_kl      = 1'b0;
        w_key_from_in   = 1'b0;
        w_key_from_pend = 1'b0;
        w_pend_capture  = 1'b0;
        key_busy        = 1'b0;
        key_ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_load) begin
                    w_state_next  = S_KEY_LOAD;
                    w_enter_kl    = 1'b1;
                    w_key_from_in = 1'b1;
                end
            end
            S_KEY_LOAD: begin
                key_busy = 1'b1;
                // Counter hits zero on the same edge that enters RUN.
                if (r_kcnt == c_KC_ONE) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                key_ready = 1'b1;
                // A pop in this same cycle still completes under the old key.
                if (key_load) begin
                    w_state_next   = S_DRAIN;
                    w_pend_capture = 1'b1;
                end
            end
            S_DRAIN: begin
                key_busy = 1'b1;
                if (r_in_flight == '0) begin
                    w_state_next    = S_KEY_LOAD;
                    w_enter_kl      = 1'b1;
                    w_key_from_pend = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kcnt      <= '0;
            r_pend_key  <= '0;
            r_dec_key   <= '0;
            r_dec_in    <= '0;
            r_fsm_en    <= 1'b0;
            r_en_sr     <= '0;
            r_in_flight <= '0;
        end else begin
            r_fsm_en <= w_enter_kl;

            if (w_enter_kl) begin
                r_kcnt <= c_KC_INIT;
            end else if (r_state == S_KEY_LOAD) begin
                r_kcnt <= r_kcnt - c_KC_W'(1);
            end

            if (w_pend_capture) begin
                r_pend_key <= key_in;
            end

            if (w_key_from_in) begin
                r_dec_key <= key_in;
            end else if (w_key_from_pend) begin
                r_dec_key <= r_pend_key;
            end

            if (w_pop) begin
                r_dec_in <= r_fifo[r_rd_ptr];
            end

            // Bit 0 is dec_enable itself; the top bit marks a block leaving
            // the core, so the count changes on the same edge as the issue.
            r_en_sr     <= {r_en_sr[PIPE_DEPTH-2:0], w_pop};
            r_in_flight <= r_in_flight + {3'b000, w_pop} - {3'b000, r_en_sr[PIPE_DEPTH-1]};
        end
    end

    assign dec_IN     = r_dec_in;
    assign dec_KEY    = r_dec_key;
    assign dec_enable = r_en_sr[0];
    assign dec_fsm_en = r_fsm_en;
    assign in_flight  = r_in_flight;

endmodule
`default_nettype wire
